// File: rtl/kalman_pkg.sv
// Shared types and saturation helpers for the multi-channel Kalman filter.
package kalman_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREDICT = 3'd1,
    DIVIDE  = 3'd2,
    UPDATE  = 3'd3,
    OUTPUT  = 3'd4
  } state_e;

  // Clamp an unsigned value to the range of a w-bit unsigned number.
  function automatic logic [63:0] sat_u(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v > max_v) ? max_v : v;
  endfunction

  // Clamp a signed value to the range of a w-bit two's-complement number.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/kalman_div.sv
// Restoring fractional divider: quot = floor(num * 2^FRAC_W / den), one bit per cycle.
// With num <= den the remainder never exceeds den, so num == den yields all ones
// (the clamped maximum gain) without a separate clamp stage.
module kalman_div #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ena,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_num,
  input  logic [DATA_W:0]   i_den,
  output logic              o_done_c,
  output logic [FRAC_W-1:0] o_quot
);

  localparam int unsigned CNT_W = $clog2(FRAC_W + 1);

  logic [DATA_W:0]   r_rem;
  logic [DATA_W:0]   r_den;
  logic [FRAC_W-1:0] r_quot;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W+1:0] w_rem2;
  logic [DATA_W+1:0] w_diff;
  logic              w_ge;

  assign w_rem2 = {r_rem, 1'b0};
  assign w_diff = w_rem2 - {1'b0, r_den};
  assign w_ge   = (w_rem2 >= {1'b0, r_den});

  // Asserted during the cycle whose closing edge produces the final quotient bit.
  assign o_done_c = i_ena && (r_cnt == CNT_W'(1));
  assign o_quot   = r_quot;

  // Operand load and shift/subtract iteration; a zero denominator is replaced by
  // all ones so the (necessarily zero) numerator yields a zero quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
    end else if (i_ena) begin
      if (i_start) begin
        r_rem  <= {1'b0, i_num};
        r_den  <= (i_den == '0) ? '1 : i_den;
        r_quot <= '0;
        r_cnt  <= CNT_W'(FRAC_W);
      end else if (r_cnt != '0) begin
        r_rem  <= (DATA_W + 1)'(w_ge ? w_diff : w_rem2);
        r_quot <= FRAC_W'({r_quot, w_ge});
        r_cnt  <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/kalman_multi.sv
// Time-shared scalar Kalman filter over N_CH independent channels.
module kalman_multi
  import kalman_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int unsigned P_INIT = 2 ** FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_z,
  input  logic [DATA_W-1:0]        q,
  input  logic [DATA_W-1:0]        r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W-1:0] out_x,
  output logic [FRAC_W-1:0]        out_k,
  output logic                     busy
);

  localparam int unsigned PW = DATA_W + FRAC_W + 2;
  localparam int unsigned KW = DATA_W + FRAC_W;

  state_e                   r_state;
  state_e                   w_next;
  logic [CH_W-1:0]          r_ch;
  logic                     r_ch_ok;
  logic signed [DATA_W-1:0] r_z;
  logic [DATA_W-1:0]        r_q;
  logic [DATA_W-1:0]        r_r;
  logic [DATA_W-1:0]        r_p_pred;
  logic signed [DATA_W-1:0] r_x [N_CH];
  logic [DATA_W-1:0]        r_p [N_CH];
  logic [N_CH-1:0]          r_primed;
  logic                     r_out_valid;
  logic [CH_W-1:0]          r_out_ch;
  logic signed [DATA_W-1:0] r_out_x;
  logic [FRAC_W-1:0]        r_out_k;

  logic                     w_accept;
  logic signed [DATA_W-1:0] w_x_cur;
  logic [DATA_W-1:0]        w_p_cur;
  logic                     w_primed_cur;
  logic [DATA_W-1:0]        w_p_pred;
  logic [DATA_W:0]          w_den;
  logic                     w_div_done;
  logic [FRAC_W-1:0]        w_k;
  logic signed [DATA_W:0]   w_e;
  logic signed [PW-1:0]     w_prod;
  logic signed [PW-1:0]     w_corr;
  logic signed [DATA_W-1:0] w_x_new;
  logic [KW-1:0]            w_kp;
  logic [DATA_W-1:0]        w_p_new;

  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_x     = r_out_x;
  assign out_k     = r_out_k;

  // Read the addressed channel's state; out-of-range channels read as zero.
  always_comb begin
    w_x_cur      = '0;
    w_p_cur      = '0;
    w_primed_cur = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_ch_ok && (r_ch == CH_W'(i))) begin
        w_x_cur      = r_x[i];
        w_p_cur      = r_p[i];
        w_primed_cur = r_primed[i];
      end
    end
  end

  // Prediction, gain denominator and update arithmetic.
  assign w_p_pred = DATA_W'(sat_u(64'(w_p_cur) + 64'(r_q), DATA_W));
  assign w_den    = (DATA_W + 1)'(w_p_pred) + (DATA_W + 1)'(r_r);
  assign w_e      = (DATA_W + 1)'(r_z) - (DATA_W + 1)'(w_x_cur);
  assign w_prod   = PW'($signed({1'b0, w_k})) * PW'(w_e);
  assign w_corr   = w_prod >>> FRAC_W;
  assign w_x_new  = DATA_W'(sat_s(64'(w_x_cur) + 64'(w_corr), DATA_W));
  assign w_kp     = KW'(w_k) * KW'(r_p_pred);
  assign w_p_new  = r_p_pred - DATA_W'(w_kp >> FRAC_W);

  kalman_div #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_ena    (ena),
    .i_start  ((r_state == PREDICT) && ena),
    .i_num    (w_p_pred),
    .i_den    (w_den),
    .o_done_c (w_div_done),
    .o_quot   (w_k)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else if (ena) r_state <= w_next;
  end

  // Next-state and handshake decode; nothing advances while ena is low.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        in_ready = ena;
        if (in_valid && ena) w_next = PREDICT;
      end
      PREDICT: if (ena) w_next = DIVIDE;
      DIVIDE:  if (w_div_done) w_next = UPDATE;
      UPDATE:  if (ena) w_next = OUTPUT;
      OUTPUT:  if (ena && out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, channel state commit and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch        <= '0;
      r_ch_ok     <= 1'b0;
      r_z         <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_p_pred    <= '0;
      r_primed    <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_x     <= '0;
      r_out_k     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_x[i] <= '0;
        r_p[i] <= DATA_W'(P_INIT);
      end
    end else if (ena) begin
      if (w_accept) begin
        r_ch    <= in_ch;
        r_ch_ok <= (32'(in_ch) < N_CH);
        r_z     <= in_z;
        r_q     <= q;
        r_r     <= r;
      end
      if (r_state == PREDICT) r_p_pred <= w_p_pred;
      if (r_state == UPDATE) begin
        r_out_valid <= 1'b1;
        r_out_ch    <= r_ch;
        if (!r_ch_ok) begin
          r_out_x <= '0;
          r_out_k <= '0;
        end else if (!w_primed_cur) begin
          r_out_x <= r_z;
          r_out_k <= {FRAC_W{1'b1}};
        end else begin
          r_out_x <= w_x_new;
          r_out_k <= w_k;
        end
        for (int i = 0; i < N_CH; i++) begin
          if (r_ch_ok && (r_ch == CH_W'(i))) begin
            r_primed[i] <= 1'b1;
            r_x[i]      <= w_primed_cur ? w_x_new : r_z;
            r_p[i]      <= w_primed_cur ? w_p_new : r_r;
          end
        end
      end
      if ((r_state == OUTPUT) && out_ready) r_out_valid <= 1'b0;
    end
  end

endmodule
